onehot_decoder_seq: RTL and testbench
=====================================

ONEHOT_DECODER_SEQ -- requirements
Module: onehot_decoder_seq

Interface
REQ-001 Parameter: N, default 2, select width in bits; legal range 1..6.
REQ-002 Derived localparam: W = 2**N, output width; not overridable.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 en  input  1  block enable; 0 forces idle and blanks the output.
REQ-006 mode  input  1  0 = direct decode, 1 = scan (ring-step through outputs).
REQ-007 in_valid  input  1  in_sel qualifier; sampled only when en=1.
REQ-008 in_sel  input  N  select index to decode, or scan reseed value.
REQ-009 out  output  W  registered one-hot output; all-zero when idle.
REQ-010 out_valid  output  1  1 when out holds a one-hot value.
REQ-011 wrap  output  1  one-cycle pulse when the scan index wraps from W-1 to 0.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, DECODE, SCAN, with a registered index idx[N-1:0].
REQ-013 All outputs SHALL be registered; latency from sampled input to out SHALL be exactly one clock.
REQ-014 In every state, en=0 SHALL move to IDLE next cycle with out=0, out_valid=0, wrap=0, idx held.
REQ-015 IDLE, en=1, mode=0, in_valid=1 SHALL go to DECODE with idx=in_sel, out=1<<in_sel, out_valid=1.
REQ-016 IDLE, en=1, mode=0, in_valid=0 SHALL remain in IDLE.
REQ-017 IDLE, en=1, mode=1 SHALL go to SCAN with idx=0, out=1, out_valid=1.
REQ-018 DECODE, en=1, mode=0: in_valid=1 SHALL update idx and out to the new in_sel; in_valid=0 SHALL hold out.
REQ-019 DECODE, en=1, mode=1 SHALL go to SCAN starting at idx=0 the next cycle.
REQ-020 SCAN, en=1, mode=1, in_valid=0 SHALL advance idx by 1 modulo W each cycle, with out=1<<idx.
REQ-021 SCAN, en=1, mode=1, in_valid=1 SHALL reseed idx=in_sel (no increment that cycle).
REQ-022 wrap SHALL be 1 for exactly the cycle out returns to bit 0 by increment from W-1; reseed to 0 SHALL NOT assert wrap.
REQ-023 SCAN, en=1, mode=0 SHALL go to DECODE holding the current idx/out, or loading in_sel if in_valid=1.
REQ-024 out SHALL never have more than one bit set; out_valid SHALL equal (out != 0).
REQ-025 Priority: rst > en=0 > in_valid reseed/load > scan increment.

Reset
REQ-026 On rst=1, asynchronously: state=IDLE, idx=0, out=0, out_valid=0, wrap=0.
REQ-027 Reset asserted mid-scan or mid-decode SHALL abort immediately; after release the block SHALL be in IDLE, with no wrap pulse.
REQ-028 The first active edge after rst deassertion SHALL apply REQ-014..REQ-023 normally.

Configuration
REQ-029 Macro DECODER_SCAN_EN SHALL compile the SCAN state, increment logic and wrap generation in.
REQ-030 Without DECODER_SCAN_EN: mode SHALL be ignored (treated as 0), SCAN unreachable, wrap tied to 0; decode behaviour is unchanged.

Verification (N=2, W=4, DECODER_SCAN_EN defined unless stated)
REQ-031 rst=1 mid-SCAN with out=4'b0100 -> out=0, out_valid=0 immediately, before the next edge; IDLE after release.
REQ-032 en=1, mode=0, in_valid pulses in_sel=1 then 3 -> out=4'b0010 one cycle later, then 4'b1000; holds with in_valid=0.
REQ-033 en=1, mode=1 held for 6 cycles from IDLE -> out=0001,0010,0100,1000,0001,0010; wrap=1 only on the 5th.
REQ-034 In SCAN, in_valid=1 with in_sel=2 -> out=4'b0100 next cycle, then 4'b1000, then 4'b0001 with wrap=1.
REQ-035 en dropped to 0 during DECODE with in_valid=1 -> out=0, out_valid=0 next cycle; in_sel ignored.
REQ-036 Build without DECODER_SCAN_EN, mode=1, in_valid=1, in_sel=3 -> out=4'b1000; wrap stays 0 for all cycles.

Source files
------------

// File: rtl/onehot_decoder_seq.sv
// Sequenced one-hot decoder: direct decode of in_sel, or ring scan through the outputs.
// Define DECODER_SCAN_EN to build in the SCAN state, index increment and wrap pulse.
module onehot_decoder_seq #(
    parameter int N = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              mode,
    input  logic              in_valid,
    input  logic [N-1:0]      in_sel,
    output logic [2**N-1:0]   out,
    output logic              out_valid,
    output logic              wrap
);
    // state    | meaning
    // S_IDLE   | output blanked, waiting for enable + request
    // S_DECODE | out = 1 << idx, idx loaded from in_sel
    // S_SCAN   | out = 1 << idx, idx steps by one each cycle (reseedable)
    localparam int W = 2**N;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_SCAN   = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [N-1:0]   idx, idx_nxt;
    logic [W-1:0]   out_nxt;
    logic           valid_nxt;
    logic           wrap_nxt;
    logic           mode_eff;

`ifdef DECODER_SCAN_EN
    logic           scan_step;
    assign mode_eff = mode;
`else
    assign mode_eff = 1'b0 & mode;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            idx       <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            out       <= out_nxt;
            out_valid <= valid_nxt;
            wrap      <= wrap_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
`ifdef DECODER_SCAN_EN
        scan_step = 1'b0;
`endif
        if (!en) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (mode_eff) begin
                        state_nxt = S_SCAN;
                        idx_nxt   = '0;
                    end else if (in_valid) begin
                        state_nxt = S_DECODE;
                        idx_nxt   = in_sel;
                    end
                end
                S_DECODE: begin
                    if (mode_eff) begin
                        state_nxt = S_SCAN;
                        idx_nxt   = '0;
                    end else if (in_valid) begin
                        idx_nxt = in_sel;
                    end
                end
`ifdef DECODER_SCAN_EN
                S_SCAN: begin
                    if (mode_eff) begin
                        if (in_valid) begin
                            idx_nxt = in_sel;
                        end else begin
                            idx_nxt   = idx + 1'b1;
                            scan_step = 1'b1;
                        end
                    end else begin
                        state_nxt = S_DECODE;
                        if (in_valid) idx_nxt = in_sel;
                    end
                end
`endif
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Outputs are computed from the next state so they register alongside it.
    always_comb begin
        out_nxt   = '0;
        valid_nxt = 1'b0;
        wrap_nxt  = 1'b0;
        if (state_nxt != S_IDLE) begin
            out_nxt   = W'(1) << idx_nxt;
            valid_nxt = 1'b1;
        end
`ifdef DECODER_SCAN_EN
        wrap_nxt = scan_step && (idx == N'(W - 1));
`endif
    end

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Scoreboard bench for onehot_decoder_seq: directed scenarios plus randomized traffic
// checked against a behavioural model; follows DECODER_SCAN_EN the same way as the design.
module tb_onehot_decoder_seq;
    localparam int N = 2;
    localparam int W = 4;
`ifdef DECODER_SCAN_EN
    localparam bit SCAN_EN = 1'b1;
`else
    localparam bit SCAN_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           en, mode, in_valid;
    logic [N-1:0]   in_sel;
    logic [W-1:0]   out;
    logic           out_valid, wrap;

    onehot_decoder_seq #(.N(N)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .in_valid(in_valid),
        .in_sel(in_sel), .out(out), .out_valid(out_valid), .wrap(wrap)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] out;
        logic         valid;
        logic         wrap;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Model: m_mode 0 = idle, 1 = decoding, 2 = scanning; m_idx is the lit output bit.
    int   m_mode = 0;
    int   m_idx  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_idx  = 0;
    endtask

    task automatic step(input logic e, input logic m, input logic v, input int s);
        exp_t x;
        bit   scan_req;
        bit   w;
        @(negedge clk);
        en = e; mode = m; in_valid = v; in_sel = N'(s);
        scan_req = SCAN_EN && m;
        w = 1'b0;
        if (!e) begin
            m_mode = 0;
        end else if (m_mode == 2 && scan_req) begin
            if (v) m_idx = s;
            else begin
                w     = (m_idx == W - 1);
                m_idx = (m_idx + 1) % W;
            end
        end else if (scan_req) begin
            m_mode = 2;
            m_idx  = 0;
        end else if (v) begin
            m_mode = 1;
            m_idx  = s;
        end else if (m_mode == 2) begin
            m_mode = 1;
        end
        x.out   = (m_mode == 0) ? '0 : W'(1 << m_idx);
        x.valid = (m_mode != 0);
        x.wrap  = w;
        q.push_back(x);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                check("out", 32'(out), 32'(x.out));
                check("out_valid", 32'(out_valid), 32'(x.valid));
                check("wrap", 32'(wrap), 32'(x.wrap));
            end
        end
    end

    initial begin : stim
        rst = 1'b1; en = 1'b0; mode = 1'b0; in_valid = 1'b0; in_sel = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out", 32'(out), 0);
        check("reset_valid", 32'(out_valid), 0);
        check("reset_wrap", 32'(wrap), 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Direct decode pulses then hold
        step(1, 0, 1, 1);
        step(1, 0, 0, 0);
        step(1, 0, 1, 3);
        step(1, 0, 0, 2);
        step(1, 0, 0, 0);
        // en drop during decode with in_valid high
        step(0, 0, 1, 2);
        step(1, 0, 0, 0);
        // Scan from idle for six cycles
        step(0, 0, 0, 0);
        repeat (6) step(1, 1, 0, 0);
        // Reseed to 2 then run through the wrap
        step(1, 1, 1, 2);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        // Reseed to 0 must not pulse wrap
        step(1, 1, 1, 3);
        step(1, 1, 1, 0);
        // Scan to decode: hold, then load
        step(1, 0, 0, 0);
        step(1, 0, 1, 2);
        // Mode 1 with a load request (decodes normally when scan is compiled out)
        step(0, 0, 0, 0);
        step(1, 1, 1, 3);
        step(1, 1, 0, 0);

        // Async reset mid-scan at out=0100
        step(0, 0, 0, 0);
        repeat (3) step(1, 1, 0, 0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_out", 32'(out), 0);
        check("async_rst_valid", 32'(out_valid), 0);
        check("async_rst_wrap", 32'(wrap), 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);

        // Randomized traffic with sticky mode to get long scans
        for (int i = 0; i < 1500; i++) begin
            logic e, m, v;
            e = ($urandom_range(0, 11) != 0);
            m = ($urandom_range(0, 7) == 0) ? ~mode : mode;
            v = ($urandom_range(0, 3) == 0);
            step(e, m, v, int'($urandom_range(0, W - 1)));
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
